// File: rtl/fsm_ring_driver.sv
// fsm_ring_driver
//   Initiator for the 8-state ring FSM (ST0..ST7). It drives the ring's serial
//   step bit and its synchronous reset. It moves the ring to a requested state
//   over the shortest path and keeps a shadow copy of the ring state. Every
//   active cycle it checks the ring's out bit against the value expected for
//   the shadow state.
//
// Parameters
//   CNT_W        width of the saturating mismatch counter
//   CHECK_EN     1 = out-checker active, 0 = err/mismatch_cnt held at 0
//
// Ports
//   c            clock
//   rst_n        asynchronous active-low reset
//   req_valid    move request valid
//   req_ready    request accepted when req_valid & req_ready at a rising edge
//   req_target   target state index 0..7
//   drv_in       to ring in: 1 = step up, 0 = step down
//   drv_rst      to ring rst (synchronous, active-high)
//   obs_out      from ring out
//   cur_state    shadow ring state index
//   busy         high in SYNC and MOVE
//   done         one-cycle pulse when the shadow reaches the latched target
//   err          sticky mismatch flag
//   mismatch_cnt saturating count of mismatching cycles
module fsm_ring_driver #(
  parameter int CNT_W    = 8,
  parameter bit CHECK_EN = 1'b1
) (
  input  logic             c,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_target,
  output logic             drv_in,
  output logic             drv_rst,
  input  logic             obs_out,
  output logic [2:0]       cur_state,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] mismatch_cnt
);

  localparam logic [1:0] ST_SYNC = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_MOVE = 2'd2;

  // Expected ring out bit, indexed by ring state (bit n = STn).
  localparam logic [7:0] EXP_OUT = 8'b0101_1001;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic [2:0]       shadow_q, shadow_d;
  logic [2:0]       target_q, target_d;
  logic             dither_q, dither_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [2:0] fwd;
  logic       at_target;
  logic       mismatch;

  // Forward distance to the target; 3-bit subtraction gives the mod-8 wrap.
  always_comb begin
    fwd       = target_q - shadow_q;
    at_target = (fwd == 3'd0);
  end

  // Moore outputs. The done cycle also behaves as the first IDLE dither step,
  // so it drives 1 and can already accept the next request.
  always_comb begin
    drv_rst   = 1'b0;
    drv_in    = 1'b0;
    req_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        drv_in    = dither_q;
      end
      ST_MOVE: begin
        busy = 1'b1;
        if (at_target) begin
          done      = 1'b1;
          drv_in    = 1'b1;
          req_ready = 1'b1;
        end else begin
          // fwd 1..4 goes up (tie at 4 goes up), 5..7 goes down.
          drv_in = (fwd <= 3'd4);
        end
      end
      default: begin
        drv_rst = 1'b1;
        busy    = 1'b1;
      end
    endcase
  end

  // Next state, shadow tracking and request capture. The ring steps every
  // clock, so the shadow always follows drv_in except while resetting the ring.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    dither_d = dither_q;
    shadow_d = drv_in ? (shadow_q + 3'd1) : (shadow_q - 3'd1);
    case (state_q)
      ST_IDLE: begin
        dither_d = ~dither_q;
        if (req_valid) begin
          target_d = req_target;
          state_d  = ST_MOVE;
        end
      end
      ST_MOVE: begin
        if (at_target) begin
          dither_d = 1'b0;
          if (req_valid) begin
            target_d = req_target;
            state_d  = ST_MOVE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        shadow_d = 3'd0;
        dither_d = 1'b1;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // Out-checker: compare the ring output with the value for the shadow state
  // in every IDLE/MOVE cycle; the flag is sticky and the counter saturates.
  always_comb begin
    mismatch = CHECK_EN && ((state_q == ST_IDLE) || (state_q == ST_MOVE)) &&
               (obs_out != EXP_OUT[shadow_q]);
    err_d    = err_q | mismatch;
    cnt_d    = cnt_q;
    if (mismatch && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_SYNC;
      shadow_q <= 3'd0;
      target_q <= 3'd0;
      dither_q <= 1'b1;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      target_q <= target_d;
      dither_q <= dither_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign cur_state    = shadow_q;
  assign err          = err_q;
  assign mismatch_cnt = cnt_q;

endmodule

// File: tb/tb_fsm_ring_driver.sv
// tb_fsm_ring_driver
//   Directed bench for fsm_ring_driver. A small ring model stands in for the
//   ring FSM and can be forced to produce a wrong out bit.
module tb_fsm_ring_driver;

  logic       c = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_target;
  logic       drv_in;
  logic       drv_rst;
  logic       obs_out;
  logic [2:0] cur_state;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] mismatch_cnt;

  logic       force_bad;
  logic [2:0] ring_q = 3'd0;

  int checks   = 0;
  int failures = 0;

  localparam logic [7:0] RING_OUT = 8'b0101_1001;

  fsm_ring_driver #(.CNT_W(8), .CHECK_EN(1'b1)) dut (
    .c            (c),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_target   (req_target),
    .drv_in       (drv_in),
    .drv_rst      (drv_rst),
    .obs_out      (obs_out),
    .cur_state    (cur_state),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .mismatch_cnt (mismatch_cnt)
  );

  always #5 c = ~c;

  // Ring model: steps every clock, synchronous reset from the driver.
  always @(posedge c) begin
    if (drv_rst) ring_q <= 3'd0;
    else if (drv_in) ring_q <= ring_q + 3'd1;
    else ring_q <= ring_q - 3'd1;
  end

  assign obs_out = RING_OUT[ring_q] ^ force_bad;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step();
    @(posedge c);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk1({tag, "_drv_rst"}, drv_rst, 1'b1);
    chk1({tag, "_drv_in"}, drv_in, 1'b0);
    chk1({tag, "_ready"}, req_ready, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b1);
    chk1({tag, "_done"}, done, 1'b0);
    chk1({tag, "_err"}, err, 1'b0);
    chk8({tag, "_cnt"}, mismatch_cnt, 8'd0);
    chk8({tag, "_cur"}, 8'(cur_state), 8'd0);
  endtask

  // Called in the first MOVE cycle. Walks d steps from entry (up or down),
  // expecting done in the last one. A conflicting request is held during the
  // non-done cycles and must be ignored. chain_v offers a new request in the
  // done cycle; otherwise the following IDLE cycle is checked.
  task automatic move_chk(input string tag, input logic [2:0] tgt,
                          input logic [2:0] entry, input int d, input logic up,
                          input logic chain_v, input logic [2:0] chain_t);
    logic [2:0] es;
    for (int i = 0; i <= d; i++) begin
      es = up ? (entry + 3'(i)) : (entry - 3'(i));
      chk8({tag, "_cur"}, 8'(cur_state), 8'(es));
      chk1({tag, "_busy"}, busy, 1'b1);
      chk1({tag, "_done"}, done, (i == d));
      chk1({tag, "_drv_in"}, drv_in, (i == d) ? 1'b1 : up);
      chk1({tag, "_ready"}, req_ready, (i == d));
      chk1({tag, "_drv_rst"}, drv_rst, 1'b0);
      if (i < d) begin
        req_valid  = 1'b1;
        req_target = ~tgt;
      end else begin
        req_valid  = chain_v;
        req_target = chain_t;
      end
      step();
    end
    req_valid = 1'b0;
    if (!chain_v) begin
      chk1({tag, "_idle_busy"}, busy, 1'b0);
      chk1({tag, "_idle_ready"}, req_ready, 1'b1);
      chk1({tag, "_idle_drv_in"}, drv_in, 1'b0);
      chk1({tag, "_idle_done"}, done, 1'b0);
      chk8({tag, "_idle_cur"}, 8'(cur_state), 8'(tgt + 3'd1));
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_target = 3'd0;
    force_bad  = 1'b0;
    repeat (2) @(posedge c);
    #1;
    check_reset_outputs("rst");

    // SYNC cycle after release
    rst_n = 1'b1;
    chk1("sync_drv_rst", drv_rst, 1'b1);
    chk1("sync_ready", req_ready, 1'b0);
    step();

    // IDLE dither: S = 0,1,0,1,0 with drv_in = 1,0,1,0,1
    for (int i = 0; i <= 4; i++) begin
      chk8("dither_cur", 8'(cur_state), 8'(i % 2));
      chk1("dither_drv_in", drv_in, (i % 2) == 0);
      chk1("dither_ready", req_ready, 1'b1);
      chk1("dither_drv_rst", drv_rst, 1'b0);
      chk1("dither_busy", busy, 1'b0);
      chk1("dither_err", err, 1'b0);
      if (i < 4) step();
    end

    // S=0 drv_in=1: T=3 -> MOVE 1,2,3
    req_valid = 1'b1; req_target = 3'd3; step();
    move_chk("mv3", 3'd3, 3'd1, 2, 1'b1, 1'b0, 3'd0);

    // S=4 drv_in=0: T=0 -> MOVE 3,2,1,0 (fwd 5, down)
    req_valid = 1'b1; req_target = 3'd0; step();
    move_chk("mv0", 3'd0, 3'd3, 3, 1'b0, 1'b0, 3'd0);
    step();
    chk8("idle_s0_cur", 8'(cur_state), 8'd0);
    chk1("idle_s0_drv_in", drv_in, 1'b1);

    // S=0 drv_in=1: T=6 -> MOVE 1,0,7,6 (wrap down)
    req_valid = 1'b1; req_target = 3'd6; step();
    move_chk("mv6w", 3'd6, 3'd1, 3, 1'b0, 1'b0, 3'd0);

    // S=7 drv_in=0: T=2 -> MOVE 6,7,0,1,2 (tie up, wrap up)
    req_valid = 1'b1; req_target = 3'd2; step();
    move_chk("mv2t", 3'd2, 3'd6, 4, 1'b1, 1'b0, 3'd0);

    // S=3 drv_in=0: T=6 -> MOVE 2,3,4,5,6 (tie up)
    req_valid = 1'b1; req_target = 3'd6; step();
    move_chk("mv6t", 3'd6, 3'd2, 4, 1'b1, 1'b0, 3'd0);

    // S=7 drv_in=0: T=6 -> MOVE entry S=6=T, done at once; chain T=0
    req_valid = 1'b1; req_target = 3'd6; step();
    move_chk("mv6z", 3'd6, 3'd6, 0, 1'b1, 1'b1, 3'd0);
    move_chk("mv0c", 3'd0, 3'd7, 1, 1'b1, 1'b0, 3'd0);

    chk1("clean_err", err, 1'b0);
    chk8("clean_cnt", mismatch_cnt, 8'd0);

    // Single wrong out cycle
    force_bad = 1'b1;
    step();
    force_bad = 1'b0;
    chk1("err1_flag", err, 1'b1);
    chk8("err1_cnt", mismatch_cnt, 8'd1);
    step();
    chk1("err1_sticky", err, 1'b1);
    chk8("err1_cnt_hold", mismatch_cnt, 8'd1);

    // Long run of wrong out cycles: counter saturates at 255
    force_bad = 1'b1;
    repeat (253) step();
    chk8("sat_254", mismatch_cnt, 8'd254);
    step();
    chk8("sat_255", mismatch_cnt, 8'd255);
    repeat (46) step();
    chk8("sat_hold", mismatch_cnt, 8'd255);
    force_bad = 1'b0;
    step();
    chk1("sat_err", err, 1'b1);
    chk8("sat_cnt_final", mismatch_cnt, 8'd255);
    chk8("sat_cur", 8'(cur_state), 8'd0);
    chk1("sat_drv_in", drv_in, 1'b1);

    // Reset mid-MOVE toward T=4 (entry S=1, fwd 3)
    req_valid = 1'b1; req_target = 3'd4; step();
    req_valid = 1'b0;
    chk1("abort_busy", busy, 1'b1);
    chk1("abort_done0", done, 1'b0);
    chk8("abort_cur0", 8'(cur_state), 8'd1);
    step();
    chk8("abort_cur1", 8'(cur_state), 8'd2);
    chk1("abort_done1", done, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort_rst");
    repeat (2) @(posedge c);
    #1;
    check_reset_outputs("abort_hold");
    rst_n = 1'b1;
    chk1("resync_drv_rst", drv_rst, 1'b1);
    chk1("resync_done", done, 1'b0);
    step();
    chk8("resync_cur0", 8'(cur_state), 8'd0);
    chk1("resync_drv_in0", drv_in, 1'b1);
    chk1("resync_ready", req_ready, 1'b1);
    chk1("resync_busy", busy, 1'b0);
    chk1("resync_done_idle", done, 1'b0);
    step();
    chk8("resync_cur1", 8'(cur_state), 8'd1);
    chk1("resync_drv_in1", drv_in, 1'b0);
    chk1("resync_err", err, 1'b0);
    chk8("resync_cnt", mismatch_cnt, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fsm_ring_driver.md
# fsm_ring_driver

Initiator for the 8-state ring FSM built on `my_package_pkg::FSM_States_t` (ST0..ST7). It drives the ring's serial `in` bit and synchronous `rst`, moves the ring to a requested state over the shortest path, and keeps a shadow copy of the ring state. Each cycle it checks the ring's `out` bit against the expected per-state value and flags any mismatch. It sits beside the ring FSM in the same clock domain and is the block's only stimulus source.

## Interface
- `CNT_W`, 8: width of the saturating mismatch counter.
- `CHECK_EN`, 1: 1 = out-checker active; 0 = `err` and `mismatch_cnt` held at 0.
- `c`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset (one clock, async assert).
- `req_valid`  in  1  move request valid.
- `req_ready`  out  1  request accepted when `req_valid & req_ready` at a rising edge.
- `req_target`  in  3  target state index, 0..7 = ST0..ST7.
- `drv_in`  out  1  to ring `in`; 1 = step up (+1 mod 8), 0 = step down (−1 mod 8).
- `drv_rst`  out  1  to ring `rst` (synchronous, active-high).
- `obs_out`  in  1  from ring `out`.
- `cur_state`  out  3  shadow state index.
- `busy`  out  1  high in SYNC and MOVE.
- `done`  out  1  one-cycle pulse when the shadow equals the latched target.
- `err`  out  1  sticky mismatch flag.
- `mismatch_cnt`  out  CNT_W  saturating count of mismatching cycles.

## Operation
- The ring steps on every clock with no hold. The shadow updates on every edge: `S <= drv_in ? S+1 : S−1` (mod 8). In SYNC it updates `S <= 0` instead.
- Driver states:
  - SYNC: `drv_rst=1`, `drv_in=0`, `req_ready=0`. Lasts exactly 1 cycle after reset release, then goes to IDLE.
  - IDLE: `req_ready=1`, `drv_rst=0`. `drv_in` alternates 1,0,1,... starting with 1 in the first IDLE cycle, so the ring dithers between S and S+1.
  - MOVE: `req_ready=0`. Entered on request acceptance, which latches `req_target` as T. Each cycle, fwd = (T − S) mod 8 combinationally:
    - fwd == 0: `done=1` this cycle, `drv_in=1`, next state IDLE. This cycle counts as the first IDLE dither step; the following IDLE cycle drives 0.
    - fwd 1..4: `drv_in=1`. A tie at fwd == 4 goes up.
    - fwd 5..7: `drv_in=0`.
- `drv_in`, `req_ready`, `busy` and `done` are Moore/combinational from registered state and the shadow. No combinational path from `req_valid` to any output.
- Expected `out` per state, ST0..ST7: 1,0,0,1,1,0,1,0.
- Checker: in every IDLE/MOVE cycle, compare `obs_out` with the expected value for S.
  - On mismatch, set `err` at the next edge. `err` clears only on reset.
  - Increment `mismatch_cnt`, saturating at 2^CNT_W − 1.
  - No check in SYNC or while `rst_n` is low.
- `req_valid` while not ready is ignored; no queuing. `req_target` is sampled only at acceptance.

## Timing
- Reset values while `rst_n=0`:
  - state SYNC-pending, `drv_rst=1`, `drv_in=0`, `req_ready=0`, `busy=1`.
  - `done=0`, `err=0`, `mismatch_cnt=0`, `cur_state=0`.
- After `rst_n` release:
  - 1 SYNC cycle; the ring and shadow go to ST0 at its closing edge.
  - The first IDLE cycle has S=ST0, and `obs_out` must be 1.
- Latency: accept at edge k gives first MOVE cycle k+1 with shadow S0. `done` is asserted in cycle k+1+d, where d = min(fwd, 8−fwd) with ties going up; d ≤ 4.
- Throughput: a new request can be accepted on the edge that ends the `done` cycle.
- `rst_n` asserted mid-MOVE: immediate async return to reset values. The target is lost, no `done` is emitted, and SYNC reruns.
- Shadow wrap is modulo 8: 7+1 → 0 and 0−1 → 7.

## Test plan
- Reset release → `drv_rst` high 1 cycle. Then `cur_state`=0, `req_ready`=1, `drv_in`=1,0,1,0, `cur_state`=0,1,0,1, `err`=0.
- Accept T=3 in the IDLE cycle with S=0 (`drv_in`=1) → MOVE S=1,2,3 with `drv_in`=1,1. `done` in the 3rd MOVE cycle, `cur_state`=3, `busy` low next cycle.
- From MOVE entry S=1, T=6 (fwd=5) → `drv_in`=0,0,0; S=1,0,7,6; `done` at S=6. Checks wrap.
- MOVE entry S=2, T=6 (fwd=4) → steps up 2,3,4,5,6 (tie goes up). MOVE entry S=T → `done` in the first MOVE cycle with zero steps.
- Ring model forces `obs_out` wrong for 1 cycle → `err`=1 next cycle, `mismatch_cnt`=1, `err` stays high. Forced wrong for 300 cycles with CNT_W=8 → `mismatch_cnt` sticks at 255.
- `rst_n` pulsed low mid-MOVE toward T=4 → outputs return to reset values immediately, no `done`. The SYNC cycle repeats and the shadow restarts at ST0.
